inference_sequencer: RTL and testbench

INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

---
 rtl/inference_sequencer.sv | 169 ++++++++++++++++
 tb/tb_inference_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_sequencer.sv
// Sequences decision-tree programming and market-sample traversals for an
// external inference engine, queuing samples and returning one result per sample.
module inference_sequencer #(
  parameter int MAX_NODES   = 64,
  parameter int ADDR_WIDTH  = $clog2(MAX_NODES),
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = MAX_NODES + 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ADDR_WIDTH-1:0]     cfg_addr,
  input  logic [2*ADDR_WIDTH+11:0]  cfg_node,
  input  logic                      cfg_last,
  input  logic                      mkt_valid,
  output logic                      mkt_ready,
  input  logic [7:0]                mkt_data,
  output logic                      dt_sw_we,
  output logic [ADDR_WIDTH-1:0]     dt_sw_addr,
  output logic                      dt_sw_is_leaf,
  output logic [7:0]                dt_sw_threshold,
  output logic                      dt_sw_less_than,
  output logic [ADDR_WIDTH-1:0]     dt_sw_left_idx,
  output logic [ADDR_WIDTH-1:0]     dt_sw_right_idx,
  output logic [1:0]                dt_sw_action,
  output logic [7:0]                dt_market_input,
  output logic                      dt_start,
  input  logic [1:0]                dt_action,
  input  logic                      dt_action_valid,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [1:0]                res_action,
  output logic [7:0]                res_market,
  output logic                      tree_loaded,
  output logic                      timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {LOAD, IDLE, START, WAIT, RESULT} state_t;

  state_t state, state_n;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             fifo_full, fifo_empty, push, pop;
  logic             cfg_beat, timeout_hit;
  logic [CNT_W-1:0] wait_cnt;

  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign mkt_ready  = ~fifo_full;
  assign push       = mkt_valid & ~fifo_full;
  assign cfg_beat   = cfg_valid & cfg_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    cfg_ready   = 1'b0;
    dt_start    = 1'b0;
    res_valid   = 1'b0;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_beat && cfg_last) state_n = IDLE;
      end
      IDLE: begin
        cfg_ready = 1'b1;
        // A pending reload always beats a queued sample.
        if (cfg_beat) begin
          state_n = cfg_last ? IDLE : LOAD;
        end else if (tree_loaded && !fifo_empty && !cfg_valid) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        dt_start = 1'b1;
        state_n  = WAIT;
      end
      WAIT: begin
        if (dt_action_valid) begin
          state_n = RESULT;
        end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_hit = 1'b1;
          state_n     = RESULT;
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_n = IDLE;
      end
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mkt_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt_sw_we        <= 1'b0;
      dt_sw_addr      <= '0;
      dt_sw_is_leaf   <= 1'b0;
      dt_sw_threshold <= '0;
      dt_sw_less_than <= 1'b0;
      dt_sw_left_idx  <= '0;
      dt_sw_right_idx <= '0;
      dt_sw_action    <= '0;
      tree_loaded     <= 1'b0;
    end else begin
      dt_sw_we <= cfg_beat;
      if (cfg_beat) begin
        dt_sw_addr <= cfg_addr;
        {dt_sw_is_leaf, dt_sw_threshold, dt_sw_less_than,
         dt_sw_left_idx, dt_sw_right_idx, dt_sw_action} <= cfg_node;
        // Any beat invalidates the resident image until its last beat lands.
        tree_loaded <= cfg_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt_market_input <= '0;
      res_market      <= '0;
      res_action      <= '0;
      timeout_err     <= 1'b0;
      wait_cnt        <= '0;
    end else begin
      if (pop) begin
        dt_market_input <= fifo_mem[rd_ptr];
        res_market      <= fifo_mem[rd_ptr];
      end
      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else               wait_cnt <= '0;
      if (state == WAIT && dt_action_valid) res_action <= dt_action;
      else if (timeout_hit)                 res_action <= '0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// Scoreboard bench for inference_sequencer with a behavioural engine that
// answers each dt_start after a fixed latency using the 3-node test tree.
module tb_inference_sequencer;

  localparam int AW  = 6;
  localparam int NW  = 2*AW + 12;
  localparam int TO  = 68;
  localparam logic [1:0] BUY  = 2'b01;
  localparam logic [1:0] SELL = 2'b10;

  logic          clk = 0, rst = 1;
  logic          cfg_valid = 0, cfg_ready, cfg_last = 0;
  logic [AW-1:0] cfg_addr = '0;
  logic [NW-1:0] cfg_node = '0;
  logic          mkt_valid = 0, mkt_ready;
  logic [7:0]    mkt_data = '0;
  logic          dt_sw_we, dt_sw_is_leaf, dt_sw_less_than;
  logic [AW-1:0] dt_sw_addr, dt_sw_left_idx, dt_sw_right_idx;
  logic [7:0]    dt_sw_threshold, dt_market_input, res_market;
  logic [1:0]    dt_sw_action, res_action;
  logic          dt_start, res_valid, res_ready = 1, tree_loaded, timeout_err;
  logic [1:0]    dt_action = '0;
  logic          dt_action_valid = 0;

  inference_sequencer #(.MAX_NODES(64), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_node(cfg_node), .cfg_last(cfg_last),
    .mkt_valid(mkt_valid), .mkt_ready(mkt_ready), .mkt_data(mkt_data),
    .dt_sw_we(dt_sw_we), .dt_sw_addr(dt_sw_addr), .dt_sw_is_leaf(dt_sw_is_leaf),
    .dt_sw_threshold(dt_sw_threshold), .dt_sw_less_than(dt_sw_less_than),
    .dt_sw_left_idx(dt_sw_left_idx), .dt_sw_right_idx(dt_sw_right_idx),
    .dt_sw_action(dt_sw_action), .dt_market_input(dt_market_input),
    .dt_start(dt_start), .dt_action(dt_action), .dt_action_valid(dt_action_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_action(res_action),
    .res_market(res_market), .tree_loaded(tree_loaded), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int sw_cnt = 0, start_cnt = 0;
  logic [NW+AW-1:0] cfg_q [$];
  logic [9:0]       exp_q [$];
  bit engine_en = 1, stray = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic logic [NW-1:0] mk_node(input logic leaf, input logic [7:0] thr,
      input logic lt, input logic [AW-1:0] l, input logic [AW-1:0] r, input logic [1:0] act);
    return {leaf, thr, lt, l, r, act};
  endfunction

  function automatic logic [1:0] tree_eval(input logic [7:0] x);
    return (x < 8'd100) ? BUY : SELL;
  endfunction

  // Behavioural engine: answers 3 cycles after dt_start unless disabled.
  int unsigned eng_cd = 0;
  logic [1:0]  eng_act = '0;
  always @(posedge clk) begin
    #1;
    dt_action_valid = 0;
    if (rst) eng_cd = 0;
    else if (stray) begin
      dt_action_valid = 1; dt_action = SELL;
    end else if (dt_start && engine_en) begin
      eng_cd = 3; eng_act = tree_eval(dt_market_input);
    end else if (eng_cd != 0) begin
      eng_cd--;
      if (eng_cd == 0) begin dt_action_valid = 1; dt_action = eng_act; end
    end
  end

  always @(negedge clk) begin
    if (dt_start) start_cnt++;
    if (dt_sw_we) begin
      sw_cnt++;
      if (cfg_q.size() == 0) check("sw_unexpected", 32'(cfg_q.size()), 1);
      else begin
        logic [NW+AW-1:0] e;
        e = cfg_q.pop_front();
        check("sw_addr", dt_sw_addr, e[NW+AW-1:NW]);
        check("sw_node", {dt_sw_is_leaf, dt_sw_threshold, dt_sw_less_than,
                          dt_sw_left_idx, dt_sw_right_idx, dt_sw_action}, e[NW-1:0]);
      end
    end
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) check("res_unexpected", 32'(exp_q.size()), 1);
      else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("res_action", res_action, e[9:8]);
        check("res_market", res_market, e[7:0]);
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_beat(input logic [AW-1:0] a, input logic [NW-1:0] n, input logic last);
    bit ok = 0;
    cfg_valid = 1; cfg_addr = a; cfg_node = n; cfg_last = last;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = cfg_ready;
      @(posedge clk); #1;
    end
    if (ok) cfg_q.push_back({a, n});
    else check("cfg_accept_timeout", 0, 1);
  endtask

  task automatic load_tree();
    cfg_beat(6'd0, mk_node(0, 8'd100, 1, 6'd1, 6'd2, 2'b00), 0);
    cfg_beat(6'd1, mk_node(1, 8'd0, 0, 6'd0, 6'd0, BUY), 0);
    cfg_beat(6'd2, mk_node(1, 8'd0, 0, 6'd0, 6'd0, SELL), 1);
    cfg_valid = 0; cfg_last = 0;
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] act, input bit track);
    bit ok = 0;
    mkt_valid = 1; mkt_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = mkt_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("mkt_accept_timeout", 0, 1);
    else if (track) exp_q.push_back({act, d});
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_pending", 32'(exp_q.size()), 0);
    cycles(2);
  endtask

  int snap, n;

  initial begin
    cycles(3);
    rst = 0;
    #1;
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_mkt_ready", mkt_ready, 1);
    check("rst_tree_loaded", tree_loaded, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_dt_start", dt_start, 0);
    check("rst_sw_we", dt_sw_we, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_outs", {dt_market_input, res_market, res_action}, 0);

    // 3-node tree load
    sync();
    snap = sw_cnt;
    load_tree();
    cycles(2);
    check("load_sw_pulses", sw_cnt - snap, 3);
    check("load_tree_loaded", tree_loaded, 1);

    // Two back-to-back samples, each answered by its own traversal
    sync();
    snap = start_cnt;
    push(8'd50, BUY, 1);
    push(8'd150, SELL, 1);
    mkt_valid = 0;
    drain();
    check("b2b_starts", start_cnt - snap, 2);

    // Stray strobe in IDLE is ignored
    @(negedge clk) stray = 1;
    @(negedge clk) stray = 0;
    cycles(3);
    check("stray_idle_res_valid", res_valid, 0);

    // Backpressure: FIFO fills while a result is held
    sync();
    res_ready = 0;
    snap = start_cnt;
    push(8'd10, BUY, 1);
    push(8'd20, BUY, 1);
    push(8'd120, SELL, 1);
    push(8'd99, BUY, 1);
    push(8'd100, SELL, 1);
    cycles(10);
    check("bp_mkt_ready", mkt_ready, 0);
    check("bp_single_start", start_cnt - snap, 1);
    check("bp_res_valid", res_valid, 1);
    @(negedge clk) stray = 1;
    @(negedge clk) stray = 0;
    cycles(20);
    check("bp_res_held", res_valid, 1);
    check("bp_mkt_ready_held", mkt_ready, 0);
    check("bp_res_action_held", res_action, BUY);
    sync();
    mkt_valid = 0;
    res_ready = 1;
    drain();
    check("bp_all_starts", start_cnt - snap, 5);

    // Engine timeout
    @(negedge clk) engine_en = 0;
    sync();
    res_ready = 0;
    push(8'd120, 2'b00, 1);
    mkt_valid = 0;
    n = 0;
    for (int i = 0; i < 20 && !dt_start; i++) @(negedge clk);
    check("to_start_seen", dt_start, 1);
    for (int i = 0; i < 300 && !res_valid; i++) begin @(negedge clk); n++; end
    check("to_latency", n - 1, TO);
    check("to_err", timeout_err, 1);
    sync();
    res_ready = 1;
    drain();
    check("to_err_sticky", timeout_err, 1);
    @(negedge clk) engine_en = 1;

    // Reload wins over a queued sample
    sync();
    res_ready = 0;
    push(8'd30, BUY, 1);
    mkt_valid = 0;
    for (int i = 0; i < 50 && !res_valid; i++) @(negedge clk);
    check("rl_first_res", res_valid, 1);
    sync();
    push(8'd200, SELL, 1);
    mkt_valid = 0;
    snap = start_cnt;
    res_ready = 1;
    load_tree();
    check("rl_no_start", start_cnt - snap, 0);
    check("rl_tree_loaded", tree_loaded, 1);
    drain();
    check("rl_after_start", start_cnt - snap, 1);

    // Reset during WAIT
    @(negedge clk) engine_en = 0;
    sync();
    push(8'd77, 2'b00, 0);
    push(8'd88, 2'b00, 0);
    mkt_valid = 0;
    cycles(6);
    @(negedge clk) rst = 1;
    #1;
    check("wrst_res_valid", res_valid, 0);
    check("wrst_dt_start", dt_start, 0);
    check("wrst_tree_loaded", tree_loaded, 0);
    check("wrst_timeout_err", timeout_err, 0);
    check("wrst_cfg_ready", cfg_ready, 1);
    check("wrst_mkt_ready", mkt_ready, 1);
    check("wrst_outs", {dt_market_input, res_market, res_action}, 0);
    @(negedge clk) begin rst = 0; engine_en = 1; end
    snap = start_cnt;
    cycles(20);
    check("wrst_no_start", start_cnt - snap, 0);
    check("wrst_load_state", cfg_ready, 1);
    sync();
    push(8'd60, BUY, 1);
    mkt_valid = 0;
    cycles(5);
    check("wrst_needs_tree", start_cnt - snap, 0);
    sync();
    load_tree();
    drain();
    check("wrst_one_start", start_cnt - snap, 1);
    check("cfg_q_empty", 32'(cfg_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
